// File: rtl/dii_package.sv
// Debug interconnect flit type shared by the debug interface, tiles and ring fabric.
package dii_package;
    typedef struct packed {
        logic        valid;
        logic        last;
        logic [15:0] data;
    } dii_flit;
endpackage

// File: rtl/riscv_dbg_ring_pkg.sv
// Serpentine ordering helpers for the debug ring fabric.
package riscv_dbg_ring_pkg;
    // Even rows run x ascending, odd rows run x descending.
    function automatic int serp_pos(int x, int y, int cols);
        return y * cols + (((y % 2) != 0) ? (cols - 1 - x) : x);
    endfunction

    function automatic int serp_tile(int p, int cols);
        int row;
        int off;
        row = p / cols;
        off = p % cols;
        return row * cols + (((row % 2) != 0) ? (cols - 1 - off) : off);
    endfunction

    function automatic int cnt_width(int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/riscv_dbg_ring_fifo.sv
// One ring hop for one channel: elastic FIFO with a registered head and
// a ready that depends only on the local fill level.
module riscv_dbg_ring_fifo
    import dii_package::*;
    import riscv_dbg_ring_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  dii_flit in_flit,
    output logic    in_ready,
    output dii_flit out_flit,
    input  logic    out_ready
);
    localparam int CW = cnt_width(DEPTH);
    localparam int AW = $clog2(DEPTH);

    dii_flit         mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // A full FIFO refuses input even if it pops this cycle, which keeps
    // downstream ready out of the upstream ready path.
    assign in_ready = !full && !rst;
    assign out_flit = (empty || rst) ? '0 : mem[rd_ptr];

    assign push = in_flit.valid && in_ready;
    assign pop  = out_flit.valid && out_ready;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in_flit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/riscv_dbg_ring_serpentine.sv
// Serpentine debug ring: host -> tiles in serpentine order -> host, one FIFO per hop per channel.
// Optional per-hop packet counters and stall flags under RISCV_DBG_RING_STATS_EN.
module riscv_dbg_ring_serpentine
    import dii_package::*;
    import riscv_dbg_ring_pkg::*;
#(
    parameter  int X             = 2,
    parameter  int Y             = 2,
    parameter  int RING_CHANNELS = 2,
    parameter  int BUF_DEPTH     = 2,
    localparam int NODES         = X * Y,
    localparam int HOPS          = NODES + 1
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  dii_flit [RING_CHANNELS-1:0]               host_ring_out,
    output logic    [RING_CHANNELS-1:0]               host_ring_out_ready,
    output dii_flit [RING_CHANNELS-1:0]               host_ring_in,
    input  logic    [RING_CHANNELS-1:0]               host_ring_in_ready,
    input  dii_flit [NODES-1:0][RING_CHANNELS-1:0]    tile_ring_out,
    output logic    [NODES-1:0][RING_CHANNELS-1:0]    tile_ring_out_ready,
    output dii_flit [NODES-1:0][RING_CHANNELS-1:0]    tile_ring_in,
    input  logic    [NODES-1:0][RING_CHANNELS-1:0]    tile_ring_in_ready
`ifdef RISCV_DBG_RING_STATS_EN
    ,
    output logic    [HOPS-1:0][RING_CHANNELS-1:0][31:0] hop_pkt_count,
    output logic    [HOPS-1:0][RING_CHANNELS-1:0]       hop_stall
`endif
);
    dii_flit [HOPS-1:0][RING_CHANNELS-1:0] hop_in;
    dii_flit [HOPS-1:0][RING_CHANNELS-1:0] hop_out;
    logic    [HOPS-1:0][RING_CHANNELS-1:0] hop_in_ready;
    logic    [HOPS-1:0][RING_CHANNELS-1:0] hop_out_ready;

    for (genvar h = 0; h < HOPS; h++) begin : g_hop
        // Hop h is fed by the host (h == 0) or by the tile at position h-1.
        if (h == 0) begin : g_src_host
            assign hop_in[h]           = host_ring_out;
            assign host_ring_out_ready = hop_in_ready[h];
        end else begin : g_src_tile
            localparam int T = serp_tile(h - 1, X);
            assign hop_in[h]              = tile_ring_out[T];
            assign tile_ring_out_ready[T] = hop_in_ready[h];
        end

        if (h == NODES) begin : g_dst_host
            assign host_ring_in     = hop_out[h];
            assign hop_out_ready[h] = host_ring_in_ready;
        end else begin : g_dst_tile
            localparam int T = serp_tile(h, X);
            assign tile_ring_in[T]  = hop_out[h];
            assign hop_out_ready[h] = tile_ring_in_ready[T];
        end

        for (genvar c = 0; c < RING_CHANNELS; c++) begin : g_ch
            riscv_dbg_ring_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
                .clk       (clk),
                .rst       (rst),
                .in_flit   (hop_in[h][c]),
                .in_ready  (hop_in_ready[h][c]),
                .out_flit  (hop_out[h][c]),
                .out_ready (hop_out_ready[h][c])
            );

`ifdef RISCV_DBG_RING_STATS_EN
            always_ff @(posedge clk) begin
                if (rst) begin
                    hop_pkt_count[h][c] <= '0;
                    hop_stall[h][c]     <= 1'b0;
                end else begin
                    if (hop_in[h][c].valid && hop_in_ready[h][c] && hop_in[h][c].last)
                        hop_pkt_count[h][c] <= hop_pkt_count[h][c] + 32'd1;
                    hop_stall[h][c] <= hop_out[h][c].valid && !hop_out_ready[h][c];
                end
            end
`endif
        end
    end
endmodule

// File: tb/tb_riscv_dbg_ring_serpentine.sv
// Randomized bench for the serpentine debug ring (3x2 mesh) against a queue-based ring model.
module tb_riscv_dbg_ring_serpentine;
    import dii_package::*;

    localparam int X     = 3;
    localparam int Y     = 2;
    localparam int CH    = 2;
    localparam int DEPTH = 2;
    localparam int NODES = X * Y;
    localparam int HOPS  = NODES + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dii_flit [CH-1:0]            host_ring_out;
    dii_flit [CH-1:0]            host_ring_in;
    logic    [CH-1:0]            host_ring_out_ready;
    logic    [CH-1:0]            host_ring_in_ready;
    dii_flit [NODES-1:0][CH-1:0] tile_ring_out;
    dii_flit [NODES-1:0][CH-1:0] tile_ring_in;
    logic    [NODES-1:0][CH-1:0] tile_ring_out_ready;
    logic    [NODES-1:0][CH-1:0] tile_ring_in_ready;
    logic    [NODES-1:0][CH-1:0] en;
`ifdef RISCV_DBG_RING_STATS_EN
    logic [HOPS-1:0][CH-1:0][31:0] hop_pkt_count;
    logic [HOPS-1:0][CH-1:0]       hop_stall;
`endif

    riscv_dbg_ring_serpentine #(.X(X), .Y(Y), .RING_CHANNELS(CH), .BUF_DEPTH(DEPTH)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .host_ring_out       (host_ring_out),
        .host_ring_out_ready (host_ring_out_ready),
        .host_ring_in        (host_ring_in),
        .host_ring_in_ready  (host_ring_in_ready),
        .tile_ring_out       (tile_ring_out),
        .tile_ring_out_ready (tile_ring_out_ready),
        .tile_ring_in        (tile_ring_in),
        .tile_ring_in_ready  (tile_ring_in_ready)
`ifdef RISCV_DBG_RING_STATS_EN
        ,
        .hop_pkt_count       (hop_pkt_count),
        .hop_stall           (hop_stall)
`endif
    );

    // Tiles forward flits with zero latency and tag the data: d' = d*7 + (index+1).
    // A disabled tile neither accepts nor emits.
    always_comb begin
        tile_ring_out      = '0;
        tile_ring_in_ready = '0;
        for (int t = 0; t < NODES; t++) begin
            for (int c = 0; c < CH; c++) begin
                if (tile_ring_in[t][c].valid && en[t][c]) begin
                    tile_ring_out[t][c].valid = 1'b1;
                    tile_ring_out[t][c].last  = tile_ring_in[t][c].last;
                    tile_ring_out[t][c].data  = tile_ring_in[t][c].data * 16'd7 + 16'(t + 1);
                end
                tile_ring_in_ready[t][c] = tile_ring_out_ready[t][c] && en[t][c];
            end
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    dii_flit q [HOPS][CH][$];
`ifdef RISCV_DBG_RING_STATS_EN
    logic [31:0] m_cnt   [HOPS][CH];
    logic        m_stall [HOPS][CH];
`endif

    function automatic int tile_at(int p);
        int row;
        int off;
        row = p / X;
        off = p % X;
        return row * X + ((row % 2 == 1) ? (X - 1 - off) : off);
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Sample just after the falling edge, compare against the model, advance the model.
    task automatic cycle();
        dii_flit [HOPS-1:0][CH-1:0]  mo;
        dii_flit [HOPS-1:0][CH-1:0]  mi;
        logic    [HOPS-1:0][CH-1:0]  mr;
        logic    [HOPS-1:0][CH-1:0]  dr;
        dii_flit [NODES-1:0][CH-1:0] e_tin;
        logic    [NODES-1:0][CH-1:0] e_tor;
        dii_flit [CH-1:0]            e_hin;
        int t;
        #1;
        e_tin = '0; e_tor = '0; e_hin = '0; mi = '0; dr = '0;
        for (int h = 0; h < HOPS; h++)
            for (int c = 0; c < CH; c++) begin
                mo[h][c] = (!rst && q[h][c].size() > 0) ? q[h][c][0] : '0;
                mr[h][c] = !rst && (q[h][c].size() < DEPTH);
            end
        for (int h = 0; h < HOPS; h++)
            for (int c = 0; c < CH; c++) begin
                if (h == 0) begin
                    mi[h][c] = host_ring_out[c];
                end else begin
                    t = tile_at(h - 1);
                    if (mo[h-1][c].valid && en[t][c]) begin
                        mi[h][c].valid = 1'b1;
                        mi[h][c].last  = mo[h-1][c].last;
                        mi[h][c].data  = mo[h-1][c].data * 16'd7 + 16'(t + 1);
                    end
                end
                if (h < NODES) begin
                    t = tile_at(h);
                    dr[h][c]    = mr[h+1][c] && en[t][c];
                    e_tin[t][c] = mo[h][c];
                    e_tor[t][c] = mr[h+1][c];
                end else begin
                    dr[h][c] = host_ring_in_ready[c];
                    e_hin[c] = mo[h][c];
                end
            end
        chk("host_ring_in", 256'(host_ring_in), 256'(e_hin));
        chk("host_ring_out_ready", 256'(host_ring_out_ready), 256'(mr[0]));
        chk("tile_ring_in", 256'(tile_ring_in), 256'(e_tin));
        chk("tile_ring_out_ready", 256'(tile_ring_out_ready), 256'(e_tor));
`ifdef RISCV_DBG_RING_STATS_EN
        for (int h = 0; h < HOPS; h++) begin
            chk("hop_pkt_count", 256'({hop_pkt_count[h][1], hop_pkt_count[h][0]}),
                256'({m_cnt[h][1], m_cnt[h][0]}));
            chk("hop_stall", 256'(hop_stall[h]), 256'({m_stall[h][1], m_stall[h][0]}));
        end
`endif
        for (int h = 0; h < HOPS; h++)
            for (int c = 0; c < CH; c++) begin
                if (rst) begin
                    q[h][c].delete();
                end else begin
                    if (mo[h][c].valid && dr[h][c]) void'(q[h][c].pop_front());
                    if (mi[h][c].valid && mr[h][c]) q[h][c].push_back(mi[h][c]);
                end
`ifdef RISCV_DBG_RING_STATS_EN
                if (rst) begin
                    m_cnt[h][c]   = '0;
                    m_stall[h][c] = 1'b0;
                end else begin
                    if (mi[h][c].valid && mr[h][c] && mi[h][c].last) m_cnt[h][c] = m_cnt[h][c] + 32'd1;
                    m_stall[h][c] = mo[h][c].valid && !dr[h][c];
                end
`endif
            end
        @(negedge clk);
    endtask

    dii_flit pin;
    int acc;

    initial begin
        rst                = 1'b1;
        host_ring_out      = '0;
        host_ring_in_ready = '1;
        en                 = '1;
        @(negedge clk);

        // Reset: readies low while rst is high.
        #1;
        chk("rst_host_ready", 256'(host_ring_out_ready), 256'(0));
        chk("rst_tile_ready", 256'(tile_ring_out_ready), 256'(0));
        cycle();
        cycle();
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 256'({host_ring_out_ready, tile_ring_out_ready}), 256'({(NODES+1)*CH{1'b1}}));
        cycle();

        // Order and latency pin: data 0 through tags 1,2,3,6,5,4 -> 22971, at host 7 cycles later.
        host_ring_out[0] = '{valid: 1'b1, last: 1'b1, data: 16'h0000};
        cycle();
        host_ring_out = '0;
        repeat (5) cycle();
        #1;
        chk("latency_not_early", 256'(host_ring_in[0].valid), 256'(0));
        cycle();
        #1;
        pin = '{valid: 1'b1, last: 1'b1, data: 16'd22971};
        chk("serpentine_order", 256'(host_ring_in[0]), 256'(pin));
        cycle();

        // Backpressure: tile at position 0 stalls channel 0, host streams.
        en[0][0] = 1'b0;
        acc = 0;
        host_ring_out[0] = '{valid: 1'b1, last: 1'b0, data: 16'h0100};
        repeat (6) begin
            #1;
            if (host_ring_out_ready[0]) acc++;
            cycle();
            if (acc > 0) host_ring_out[0].data = 16'h0100 + 16'(acc);
        end
        #1;
        chk("bp_accepted", 256'(acc), 256'(2));
        chk("bp_ready_low", 256'(host_ring_out_ready[0]), 256'(0));
        en = '1;
        host_ring_out[0].last = 1'b1;
        repeat (3) cycle();
        host_ring_out = '0;
        repeat (12) cycle();

        // Random traffic, random readies on both channels.
        repeat (1000) begin
            for (int c = 0; c < CH; c++) begin
                host_ring_out[c].valid = ($urandom_range(0, 3) != 0);
                host_ring_out[c].last  = ($urandom_range(0, 2) == 0);
                host_ring_out[c].data  = 16'($urandom);
                host_ring_in_ready[c]  = ($urandom_range(0, 3) != 0);
            end
            for (int t = 0; t < NODES; t++)
                for (int c = 0; c < CH; c++)
                    en[t][c] = ($urandom_range(0, 6) != 0);
            cycle();
        end

        // Reset with flits buffered.
        en = '1;
        host_ring_in_ready = '0;
        host_ring_out[0] = '{valid: 1'b1, last: 1'b0, data: 16'h0A0A};
        host_ring_out[1] = '{valid: 1'b1, last: 1'b1, data: 16'h0B0B};
        repeat (12) cycle();
        rst = 1'b1;
        #1;
        chk("rst_flits_zero", 256'({host_ring_in, tile_ring_in}), 256'(0));
        chk("rst_readies_zero", 256'({host_ring_out_ready, tile_ring_out_ready}), 256'(0));
        cycle();
        rst = 1'b0;
        host_ring_out = '0;
        host_ring_in_ready = '1;
        #1;
        chk("post_rst_ready", 256'({host_ring_out_ready, tile_ring_out_ready}), 256'({(NODES+1)*CH{1'b1}}));
        chk("post_rst_empty", 256'({host_ring_in, tile_ring_in}), 256'(0));
        cycle();

`ifdef RISCV_DBG_RING_STATS_EN
        // Four single-flit packets on channel 1 pass every hop.
        repeat (4) begin
            host_ring_out[1] = '{valid: 1'b1, last: 1'b1, data: 16'h5A5A};
            cycle();
        end
        host_ring_out = '0;
        repeat (12) cycle();
        for (int h = 0; h < HOPS; h++)
            chk("stats_pkt_count", 256'(hop_pkt_count[h][1]), 256'(4));
`endif
        repeat (4) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
